// File: rtl/sys_bus_ctrl_if.sv
// rtl/sys_bus_ctrl_if.sv - CPU-side bus bundle for the system bus controller
interface sys_bus_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_din;
    logic          hold;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_dout,
        input  cpu_din, hold
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_dout,
        output cpu_din, hold
    );
endinterface

// File: rtl/sys_bus_ctrl.sv
// rtl/sys_bus_ctrl.sv - address decoder, read-data mux, EXT wait-state FSM and error tracker
module sys_bus_ctrl #(
    parameter int             DW         = 16,
    parameter int             AW         = 16,
    parameter int             DB         = 4,
    parameter logic [DB-1:0]  RAM_TAG    = 4'h0,
    parameter logic [DB-1:0]  IO_TAG     = 4'h2,
    parameter logic [DB-1:0]  EXT_TAG    = 4'h4,
    parameter logic [DB-1:0]  ROM_TAG    = 4'hF,
    parameter int             EXT_WAIT   = 2,
    parameter logic [DW-1:0]  UNMAP_DATA = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    sys_bus_ctrl_if.slave       cpu,
    input  logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       io_din,
    input  logic [DW-1:0]       rom_din,
    input  logic [DW-1:0]       ext_din,
    output logic                ram_we,
    output logic                io_we,
    output logic                ext_we,
    output logic                ext_sel,
    output logic                bus_err,
    output logic [AW-1:0]       err_addr,
    output logic [7:0]          err_cnt,
    input  logic                err_clr
);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXT_WAIT_ST,
        EXT_DONE
    } state_t;

    typedef enum logic [2:0] {
        RG_RAM,
        RG_IO,
        RG_ROM,
        RG_EXT,
        RG_UNMAP
    } region_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wlat_q, wlat_d;
    region_t         region;
    region_t         rd_region_q;
    logic            rd_valid_q;
    logic [DB-1:0]   tag;
    logic            accepted;
    logic            err_hit;
    logic            hold_c;
    logic            ext_we_c;
    logic            ext_sel_c;
    logic            unused_bits;

    assign unused_bits = ^{cpu.cpu_dout, cpu.cpu_addr[AW-DB-1:0]};

    assign tag = cpu.cpu_addr[AW-1:AW-DB];

    always_comb begin
        region = RG_UNMAP;
        if (tag == RAM_TAG) begin
            region = RG_RAM;
        end else if (tag == IO_TAG) begin
            region = RG_IO;
        end else if (tag == EXT_TAG) begin
            region = RG_EXT;
        end else if (tag == ROM_TAG) begin
            region = RG_ROM;
        end
    end

    // While the CPU is held in a wait state its request is the stalled one, not a new access.
    assign accepted = cpu.cpu_req && (state_q != EXT_WAIT_ST);
    assign err_hit  = accepted && ((region == RG_UNMAP) || ((region == RG_ROM) && cpu.cpu_we));

    assign ram_we = reset_n && accepted && cpu.cpu_we && (region == RG_RAM);
    assign io_we  = reset_n && accepted && cpu.cpu_we && (region == RG_IO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wlat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wlat_q  <= wlat_d;
        end
    end

    // Hold covers the request cycle plus EXT_WAIT wait-state cycles; the write
    // strobe fires on the last wait state using the write flag latched at entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wlat_d    = wlat_q;
        hold_c    = 1'b0;
        ext_we_c  = 1'b0;
        ext_sel_c = 1'b0;
        case (state_q)
            IDLE, EXT_DONE: begin
                state_d = IDLE;
                if (cpu.cpu_req && (region == RG_EXT)) begin
                    if (EXT_WAIT > 0) begin
                        state_d = EXT_WAIT_ST;
                        cnt_d   = CW'(EXT_WAIT - 1);
                        wlat_d  = cpu.cpu_we;
                        hold_c  = 1'b1;
                    end else begin
                        ext_sel_c = 1'b1;
                        ext_we_c  = cpu.cpu_we;
                    end
                end
            end
            EXT_WAIT_ST: begin
                hold_c    = 1'b1;
                ext_sel_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = EXT_DONE;
                    ext_we_c = wlat_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu.hold = reset_n && hold_c;
    assign ext_we   = reset_n && ext_we_c;
    assign ext_sel  = reset_n && ext_sel_c;

    // Region is registered so the mux lines up with the one-cycle memory read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_region_q <= RG_UNMAP;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= accepted;
            if (accepted) begin
                rd_region_q <= region;
            end
        end
    end

    always_comb begin
        cpu.cpu_din = UNMAP_DATA;
        if (state_q == EXT_DONE) begin
            cpu.cpu_din = ext_din;
        end else if (rd_valid_q) begin
            case (rd_region_q)
                RG_RAM:  cpu.cpu_din = ram_din;
                RG_IO:   cpu.cpu_din = io_din;
                RG_ROM:  cpu.cpu_din = rom_din;
                RG_EXT:  cpu.cpu_din = ext_din;
                default: cpu.cpu_din = UNMAP_DATA;
            endcase
        end
    end

    // A clear coinciding with a new error wipes the old record before logging the new one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (err_clr) begin
            bus_err  <= err_hit;
            err_addr <= err_hit ? cpu.cpu_addr : '0;
            err_cnt  <= err_hit ? 8'd1 : 8'd0;
        end else if (err_hit) begin
            bus_err <= 1'b1;
            if (!bus_err) begin
                err_addr <= cpu.cpu_addr;
            end
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb/tb_sys_bus_ctrl.sv - directed self-checking bench for sys_bus_ctrl
module tb_sys_bus_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, err_clr;
    logic [15:0] cpu_addr, cpu_dout;
    logic [15:0] ram_din, io_din, rom_din, ext_din;
    logic        ram_we2, io_we2, ext_we2, ext_sel2, bus_err2;
    logic        ram_we3, io_we3, ext_we3, ext_sel3, bus_err3;
    logic [15:0] err_addr2, err_addr3;
    logic [7:0]  err_cnt2, err_cnt3;
    logic [15:0] ram_mem [0:255];

    int checks = 0;
    int failures = 0;
    int w2, w3, n2, n3, p2, p3;

    always #5 clk = ~clk;

    sys_bus_ctrl_if #(.DW(16), .AW(16)) bus2 ();
    sys_bus_ctrl_if #(.DW(16), .AW(16)) bus3 ();

    assign bus2.cpu_req  = cpu_req;
    assign bus2.cpu_we   = cpu_we;
    assign bus2.cpu_addr = cpu_addr;
    assign bus2.cpu_dout = cpu_dout;
    assign bus3.cpu_req  = cpu_req;
    assign bus3.cpu_we   = cpu_we;
    assign bus3.cpu_addr = cpu_addr;
    assign bus3.cpu_dout = cpu_dout;

    sys_bus_ctrl #(.EXT_WAIT(2)) d2 (
        .clk(clk), .reset_n(reset_n), .cpu(bus2),
        .ram_din(ram_din), .io_din(io_din), .rom_din(rom_din), .ext_din(ext_din),
        .ram_we(ram_we2), .io_we(io_we2), .ext_we(ext_we2), .ext_sel(ext_sel2),
        .bus_err(bus_err2), .err_addr(err_addr2), .err_cnt(err_cnt2), .err_clr(err_clr)
    );

    sys_bus_ctrl #(.EXT_WAIT(3)) d3 (
        .clk(clk), .reset_n(reset_n), .cpu(bus3),
        .ram_din(ram_din), .io_din(io_din), .rom_din(rom_din), .ext_din(ext_din),
        .ram_we(ram_we3), .io_we(io_we3), .ext_we(ext_we3), .ext_sel(ext_sel3),
        .bus_err(bus_err3), .err_addr(err_addr3), .err_cnt(err_cnt3), .err_clr(err_clr)
    );

    // Synchronous target memories with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we2) ram_mem[cpu_addr[7:0]] <= cpu_dout;
        ram_din <= ram_mem[cpu_addr[7:0]];
        io_din  <= 16'h1000 ^ cpu_addr;
        rom_din <= 16'hC000 | {8'h00, cpu_addr[7:0]};
        ext_din <= 16'hE000 | {4'h0, cpu_addr[11:0]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        cpu_req  = r;
        cpu_we   = w;
        cpu_addr = a;
        cpu_dout = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
        reset_n = 1'b0;
        err_clr = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        tick;
        tick;
        chk("rst_hold", bus2.hold, 0);
        chk("rst_cpu_din", bus2.cpu_din, 16'h0000);
        chk("rst_bus_err", bus_err2, 0);
        chk("rst_err_cnt", err_cnt2, 0);
        chk("rst_err_addr", err_addr2, 0);
        chk("rst_ram_we", ram_we2, 0);
        reset_n = 1'b1;
        tick;

        // RAM write then read
        drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        #1 chk("ram_wr_we", ram_we2, 1);
        chk("ram_wr_hold", bus2.hold, 0);
        tick;
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        #1 chk("ram_rd_no_we", ram_we2, 0);
        tick;
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        #1 chk("ram_rd_data", bus2.cpu_din, 16'hBEEF);
        chk("ram_rd_hold", bus2.hold, 0);
        tick;
        #1 chk("idle_din_unmap", bus2.cpu_din, 16'h0000);

        // Back-to-back RAM then IO
        drive(1'b1, 1'b1, 16'h0001, 16'h1234);
        tick;
        drive(1'b1, 1'b0, 16'h0001, 16'h0000);
        tick;
        drive(1'b1, 1'b0, 16'h2000, 16'h0000);
        #1 chk("b2b_ram_data", bus2.cpu_din, 16'h1234);
        tick;
        drive(1'b1, 1'b1, 16'h2004, 16'h5555);
        #1 chk("b2b_io_data", bus2.cpu_din, 16'h3000);
        chk("io_wr_we", io_we2, 1);
        chk("io_wr_no_ram_we", ram_we2, 0);
        tick;
        drive(1'b0, 1'b0, 16'h2004, 16'h0000);
        tick;

        // EXT read with two wait states
        drive(1'b1, 1'b0, 16'h4004, 16'h0000);
        #1 chk("ext_rd_entry_hold2", bus2.hold, 1);
        chk("ext_rd_entry_hold3", bus3.hold, 1);
        tick;
        cpu_req = 1'b0;
        w2 = 0; n2 = 0;
        for (int i = 0; i < 10 && bus2.hold; i++) begin
            if (ext_sel2) w2++;
            if (ext_we2) n2++;
            tick;
        end
        chk("ext_rd_hold_release", bus2.hold, 0);
        chk("ext_rd_wait_cycles", w2, 2);
        chk("ext_rd_no_we", n2, 0);
        chk("ext_rd_data", bus2.cpu_din, 16'hE004);
        for (int i = 0; i < 10 && bus3.hold; i++) tick;
        tick;

        // EXT write: one strobe on the last wait state
        drive(1'b1, 1'b1, 16'h4010, 16'hABCD);
        #1 chk("ext_wr_entry_hold3", bus3.hold, 1);
        chk("ext_wr_entry_no_we3", ext_we3, 0);
        tick;
        cpu_req = 1'b0;
        w2 = 0; w3 = 0; n2 = 0; n3 = 0; p2 = 0; p3 = 0;
        for (int i = 0; i < 12 && (bus2.hold || bus3.hold); i++) begin
            if (bus2.hold && ext_sel2) w2++;
            if (bus3.hold && ext_sel3) w3++;
            if (ext_we2) begin n2++; p2 = w2; end
            if (ext_we3) begin n3++; p3 = w3; end
            tick;
        end
        chk("ext_wr_hold_release", bus2.hold | bus3.hold, 0);
        chk("ext_wr_pulses3", n3, 1);
        chk("ext_wr_pos3", p3, 3);
        chk("ext_wr_waits3", w3, 3);
        chk("ext_wr_pulses2", n2, 1);
        chk("ext_wr_pos2", p2, 2);
        chk("ext_no_err", bus_err2, 0);
        tick;

        // ROM write, unmapped read, ROM read
        drive(1'b1, 1'b1, 16'hF000, 16'h1111);
        #1 chk("rom_wr_no_we", {ram_we2, io_we2, ext_we2}, 0);
        tick;
        drive(1'b1, 1'b0, 16'h8000, 16'h0000);
        #1 chk("err_set_next", bus_err2, 1);
        chk("err_cnt_1", err_cnt2, 1);
        tick;
        drive(1'b1, 1'b0, 16'hF00A, 16'h0000);
        #1 chk("unmap_rd_din", bus2.cpu_din, 16'h0000);
        chk("err_addr_first", err_addr2, 16'hF000);
        chk("err_cnt_2", err_cnt2, 2);
        tick;
        drive(1'b0, 1'b0, 16'hF00A, 16'h0000);
        #1 chk("rom_rd_din", bus2.cpu_din, 16'hC00A);
        chk("rom_rd_no_err", err_cnt2, 2);

        // Clear alone, then clear coinciding with a new error
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        #1 chk("clr_bus_err", bus_err2, 0);
        chk("clr_err_cnt", err_cnt2, 0);
        chk("clr_err_addr", err_addr2, 0);
        err_clr = 1'b1;
        drive(1'b1, 1'b0, 16'h9000, 16'h0000);
        tick;
        err_clr = 1'b0;
        drive(1'b1, 1'b1, 16'hF002, 16'h0007);
        #1 chk("clr_err_bus", bus_err2, 1);
        chk("clr_err_cnt1", err_cnt2, 1);
        chk("clr_err_addr", err_addr2, 16'h9000);
        tick;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("second_err_cnt", err_cnt2, 2);
        chk("err_addr_kept", err_addr2, 16'h9000);

        // Saturation of the error counter
        drive(1'b1, 1'b0, 16'hA000, 16'h0000);
        repeat (300) tick;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("err_cnt_sat", err_cnt2, 8'hFF);
        tick;

        // Reset in the middle of an EXT write wait
        drive(1'b1, 1'b1, 16'h4020, 16'h2222);
        tick;
        cpu_req = 1'b0;
        #1 chk("rst_pre_hold3", bus3.hold, 1);
        reset_n = 1'b0;
        #1 chk("rst_mid_hold3", bus3.hold, 0);
        chk("rst_mid_hold2", bus2.hold, 0);
        chk("rst_mid_err_cnt3", err_cnt3, 0);
        chk("rst_mid_bus_err3", bus_err3, 0);
        tick;
        tick;
        reset_n = 1'b1;
        n3 = 0;
        for (int i = 0; i < 8; i++) begin
            if (ext_we2 || ext_we3 || bus3.hold) n3++;
            tick;
        end
        chk("rst_no_ext_activity", n3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
